// File: rtl/hpc2_rnd_feeder_pkg.sv
//----------------------------------------------------------------------------
// Package : hpc2_rnd_feeder_pkg
// Purpose : Shared constants, state encoding and helper function for the
//           HPC2 fresh-randomness feeder and its unrolled LFSR.
//           - and_pini_nrnd(d): fresh random bits one HPC2 AND gadget of
//             order d consumes per evaluation (same formula as the gadgets).
//           - 128-bit Fibonacci LFSR tap positions (taps 128,126,101,99,
//             expressed as 0-based bit indices).
//           - 2-bit FSM state encoding.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package hpc2_rnd_feeder_pkg;

  localparam int LFSR_W     = 128;
  localparam int SEED_W     = 32;
  localparam int SEED_WORDS = LFSR_W / SEED_W;
  localparam int NRND_MAX   = 96;

  // Tap positions 128,126,101,99 (1-based) as 0-based indices.
  localparam int TAP_A = 127;
  localparam int TAP_B = 125;
  localparam int TAP_C = 100;
  localparam int TAP_D = 98;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_SEEDING  = 2'd1,
    ST_WARMING  = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  function automatic int and_pini_nrnd(input int order);
    return (order * (order - 1)) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hpc2_rnd_feeder_lfsr128_unroll.sv
//----------------------------------------------------------------------------
// Module  : hpc2_rnd_feeder_lfsr128_unroll
// Purpose : Purely combinational N-step unrolled next-state function of the
//           128-bit Fibonacci LFSR. Each step shifts the state left by one
//           and inserts the feedback bit at bit 0, so after N steps the N
//           newest bits sit in state_out[N-1:0] (bit 0 newest).
// Ports   : state_in  [127:0]  current LFSR state
//           state_out [127:0]  state after N steps
//           bits_out  [N-1:0]  the N bits produced by those steps
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module hpc2_rnd_feeder_lfsr128_unroll
  import hpc2_rnd_feeder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out,
  output logic [N-1:0]      bits_out
);

  always_comb begin : p_unroll
    logic [LFSR_W-1:0] s;
    s = state_in;
    for (int i = 0; i < N; i++) begin
      s = {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    end
    state_out = s;
    bits_out  = s[N-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/hpc2_rnd_feeder.sv
//----------------------------------------------------------------------------
// Module  : hpc2_rnd_feeder
// Purpose : Fresh-randomness source for NGADGETS HPC2 masked AND gadgets of
//           order d. A 128-bit seed is absorbed as four 32-bit words (least
//           significant word first), the LFSR is warmed up for WARMUP
//           cycles, and from then on every rnd_en cycle produces NRND new
//           bits on a registered output.
// Ports   : clk        in   1     clock, rising edge
//           rst_n      in   1     asynchronous active-low reset
//           seed_data  in   32    seed word
//           seed_valid in   1     seed word present
//           seed_ready out  1     seed word accepted when valid & ready
//           rnd_en     in   1     advance request (honoured only in RUN)
//           rnd        out  NRND  randomness, gadget g uses
//                                 [g*and_pini_nrnd(d) +: and_pini_nrnd(d)]
//           rnd_valid  out  1     rnd is seeded, warmed up and fresh
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module hpc2_rnd_feeder
  import hpc2_rnd_feeder_pkg::*;
#(
  parameter  int d        = 2,
  parameter  int NGADGETS = 4,
  parameter  int WARMUP   = 8,
  localparam int NRND     = NGADGETS * and_pini_nrnd(d)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEED_W-1:0] seed_data,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              rnd_en,
  output logic [NRND-1:0]   rnd,
  output logic              rnd_valid
);

  //--------------------------------------------------------------------------
  // Elaboration-time parameter checks
  //--------------------------------------------------------------------------
  generate
    if (d < 2) begin : g_bad_order
      $error("hpc2_rnd_feeder: masking order d must be >= 2");
    end
    if (NGADGETS < 1) begin : g_bad_ngadgets
      $error("hpc2_rnd_feeder: NGADGETS must be >= 1");
    end
    if (WARMUP < 1) begin : g_bad_warmup
      $error("hpc2_rnd_feeder: WARMUP must be >= 1");
    end
    if (NRND > NRND_MAX) begin : g_bad_nrnd
      $error("hpc2_rnd_feeder: NRND exceeds 96 bits");
    end
  endgenerate

  localparam int WCNT_W = $clog2(SEED_WORDS);
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(SEED_WORDS - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [LFSR_W-1:0]   lfsr_q,     lfsr_d;
  logic [NRND-1:0]     rnd_q,      rnd_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;

  logic [LFSR_W-1:0]   lfsr_adv;
  logic [NRND-1:0]     rnd_adv;
  logic [LFSR_W-1:0]   seed_shift;
  logic                seed_fire;

  hpc2_rnd_feeder_lfsr128_unroll #(
    .N (NRND)
  ) u_unroll (
    .state_in  (lfsr_q),
    .state_out (lfsr_adv),
    .bits_out  (rnd_adv)
  );

  // Each accepted word enters at the top, so after four words the first
  // (least significant) word has been pushed down to bits [31:0].
  assign seed_shift = {seed_data, lfsr_q[LFSR_W-1:SEED_W]};

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNSEEDED;
      lfsr_q     <= '0;
      rnd_q      <= '0;
      word_cnt_q <= '0;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rnd_q      <= rnd_d;
      word_cnt_q <= word_cnt_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and output logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rnd_d      = rnd_q;
    word_cnt_d = word_cnt_q;
    warm_cnt_d = warm_cnt_q;
    seed_ready = (state_q != ST_WARMING);
    rnd_valid  = (state_q == ST_RUN);
    seed_fire  = seed_valid & seed_ready;

    case (state_q)
      ST_UNSEEDED: begin
        if (seed_fire) begin
          lfsr_d     = seed_shift;
          word_cnt_d = WCNT_W'(1);
          state_d    = ST_SEEDING;
        end
      end

      ST_SEEDING: begin
        // No timeout: a stalled seed source simply leaves us here.
        if (seed_fire) begin
          lfsr_d = seed_shift;
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
            warm_cnt_d = '0;
            state_d    = ST_WARMING;
            // An all-zero state would lock the LFSR at zero forever.
            if (seed_shift == '0) begin
              lfsr_d[0] = 1'b1;
            end
          end else begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
          end
        end
      end

      ST_WARMING: begin
        // Advance every cycle; rnd tracks so RUN starts on the last value.
        lfsr_d = lfsr_adv;
        rnd_d  = rnd_adv;
        if (warm_cnt_q == WARM_LAST) begin
          warm_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end

      ST_RUN: begin
        // A reseed takes priority over an advance request in the same cycle;
        // rnd is held so the gadgets never see a recycled value.
        if (seed_fire) begin
          lfsr_d     = seed_shift;
          word_cnt_d = WCNT_W'(1);
          state_d    = ST_SEEDING;
        end else if (rnd_en) begin
          lfsr_d = lfsr_adv;
          rnd_d  = rnd_adv;
        end
      end

      default: begin
        state_d = ST_UNSEEDED;
      end
    endcase
  end

  assign rnd = rnd_q;

endmodule

`default_nettype wire

// File: tb/tb_hpc2_rnd_feeder.sv
//----------------------------------------------------------------------------
// Testbench: tb_hpc2_rnd_feeder
// Directed scenarios for hpc2_rnd_feeder (d=2, NGADGETS=4 -> NRND=4,
// WARMUP=8) checked against a bit-serial reference LFSR model.
//----------------------------------------------------------------------------
`default_nettype none

module tb_hpc2_rnd_feeder;

  localparam int NRND   = 4;
  localparam int WARMUP = 8;

  localparam logic [127:0] SEED_A = 128'h76543210_FEDCBA98_89ABCDEF_01234567;
  localparam logic [127:0] SEED_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic [31:0]     seed_data  = '0;
  logic            seed_valid = 1'b0;
  logic            rnd_en     = 1'b0;
  logic            seed_ready;
  logic            rnd_valid;
  logic [NRND-1:0] rnd;

  int errors = 0;
  int checks = 0;

  logic [127:0]    m_lfsr = '0;
  logic [NRND-1:0] m_rnd  = '0;

  always #5 clk = ~clk;

  hpc2_rnd_feeder #(
    .d        (2),
    .NGADGETS (4),
    .WARMUP   (WARMUP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_data  (seed_data),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd_en     (rnd_en),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid)
  );

  // Reference: one LFSR step at a time, feedback from taps 128,126,101,99.
  function automatic logic [127:0] m_step(input logic [127:0] s);
    logic fb;
    fb = s[127] ^ s[125] ^ s[100] ^ s[98];
    return {s[126:0], fb};
  endfunction

  task automatic m_adv();
    for (int i = 0; i < NRND; i++) m_lfsr = m_step(m_lfsr);
    m_rnd = m_lfsr[NRND-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds seed words first..3, checking readiness and that rnd is held,
  // then walks the warm-up window against the model started from 'start'.
  task automatic do_seed_warm(input logic [127:0] seed, input logic [127:0] start,
                              input int first, input logic [NRND-1:0] hold,
                              input string tag);
    for (int i = first; i < 4; i++) begin
      seed_data  = seed[32*i +: 32];
      seed_valid = 1'b1;
      checks++;
      if (seed_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_seed_ready word %0d: got %b expected 1", tag, i, seed_ready);
      end
      checks++;
      if (rnd !== hold) begin
        errors++;
        $display("FAIL %s_seed_hold word %0d: got %h expected %h", tag, i, rnd, hold);
      end
      tick();
    end
    seed_valid = 1'b0;
    seed_data  = '0;
    m_lfsr     = start;
    checks++;
    if (seed_ready !== 1'b0 || rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_warm_entry: got ready=%b valid=%b expected ready=0 valid=0",
               tag, seed_ready, rnd_valid);
    end
    for (int k = 1; k <= WARMUP; k++) begin
      tick();
      m_adv();
      checks++;
      if (rnd_valid !== 1'(k == WARMUP)) begin
        errors++;
        $display("FAIL %s_warm_valid edge %0d: got %b expected %b", tag, k, rnd_valid, k == WARMUP);
      end
      checks++;
      if (rnd !== m_rnd) begin
        errors++;
        $display("FAIL %s_warm_rnd edge %0d: got %h expected %h", tag, k, rnd, m_rnd);
      end
    end
  endtask

  // n back-to-back advances; optionally requires the output to keep moving.
  task automatic run_advances(input int n, input string tag, input bit check_activity);
    int              changes;
    logic [NRND-1:0] prev;
    changes = 0;
    rnd_en  = 1'b1;
    for (int c = 0; c < n; c++) begin
      prev = rnd;
      tick();
      m_adv();
      checks++;
      if (rnd !== m_rnd || rnd_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_run cycle %0d: got rnd=%h valid=%b expected rnd=%h valid=1",
                 tag, c, rnd, rnd_valid, m_rnd);
      end
      if (rnd !== prev) changes++;
    end
    if (check_activity) begin
      checks++;
      if (changes < n / 2) begin
        errors++;
        $display("FAIL %s_activity: got %0d changes expected at least %0d", tag, changes, n / 2);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rnd_en = c[0];
      tick();
      checks++;
      if (seed_ready !== 1'b1 || rnd_valid !== 1'b0 || rnd !== '0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got ready=%b valid=%b rnd=%h expected 1 0 0",
                 c, seed_ready, rnd_valid, rnd);
      end
    end
    rnd_en = 1'b0;
  endtask

  task automatic test_seed_run();
    rnd_en = 1'b1;
    do_seed_warm(SEED_A, SEED_A, 0, '0, "seed");
    run_advances(200, "seed", 1'b1);
  endtask

  task automatic test_zero_seed();
    bit seen;
    rnd_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n  = 1'b1;
    tick();
    do_seed_warm('0, 128'h1, 0, '0, "zero");
    seen   = 1'b0;
    rnd_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      m_adv();
      checks++;
      if (rnd !== m_rnd) begin
        errors++;
        $display("FAIL zero_run cycle %0d: got %h expected %h", c, rnd, m_rnd);
      end
      if (rnd !== '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL zero_guard_nonzero: got all-zero rnd expected nonzero");
    end
  endtask

  task automatic test_hold();
    logic [3:0]      pat;
    logic [NRND-1:0] prev;
    pat = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      prev   = rnd;
      rnd_en = pat[3-c];
      tick();
      if (pat[3-c]) m_adv();
      checks++;
      if (rnd !== m_rnd) begin
        errors++;
        $display("FAIL hold_model step %0d: got %h expected %h", c, rnd, m_rnd);
      end
      if (!pat[3-c]) begin
        checks++;
        if (rnd !== prev) begin
          errors++;
          $display("FAIL hold_held step %0d: got %h expected %h", c, rnd, prev);
        end
      end
    end
  endtask

  task automatic test_reseed();
    logic [NRND-1:0] prev;
    prev       = rnd;
    rnd_en     = 1'b1;
    seed_data  = SEED_B[31:0];
    seed_valid = 1'b1;
    checks++;
    if (seed_ready !== 1'b1) begin
      errors++;
      $display("FAIL reseed_ready: got %b expected 1", seed_ready);
    end
    tick();
    checks++;
    if (rnd_valid !== 1'b0 || rnd !== prev) begin
      errors++;
      $display("FAIL reseed_first: got valid=%b rnd=%h expected valid=0 rnd=%h", rnd_valid, rnd, prev);
    end
    do_seed_warm(SEED_B, SEED_B, 1, prev, "reseed");
    run_advances(10, "reseed", 1'b0);
  endtask

  task automatic test_reset_mid_seed();
    rnd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seed_data  = SEED_B[32*i +: 32];
      seed_valid = 1'b1;
      tick();
    end
    seed_valid = 1'b0;
    seed_data  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seed_ready !== 1'b1 || rnd_valid !== 1'b0 || rnd !== '0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b rnd=%h expected 1 0 0", seed_ready, rnd_valid, rnd);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rnd_en = 1'b1;
    do_seed_warm(SEED_A, SEED_A, 0, '0, "rerun");
    run_advances(20, "rerun", 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seed_run();
    test_zero_seed();
    test_hold();
    test_reseed();
    test_reset_mid_seed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
